// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - scan-code and ASCII constants shared by the keyboard ASCII FIFO
package kbd_pkg;

  localparam logic [8:0] SC_SHIFT_L = 9'h012;
  localparam logic [8:0] SC_SHIFT_R = 9'h059;
  localparam logic [8:0] SC_CAPS    = 9'h058;
  localparam logic [8:0] SC_ENTER   = 9'h05A;
  localparam logic [8:0] SC_BKSP    = 9'h066;
  localparam logic [8:0] SC_SPACE   = 9'h029;

  localparam logic [6:0] ASCII_NUL     = 7'h00;
  localparam logic [6:0] ASCII_CR      = 7'h0D;
  localparam logic [6:0] ASCII_SPACE   = 7'h20;
  localparam logic [6:0] ASCII_ZERO    = 7'h30;
  localparam logic [6:0] ASCII_UPPER_A = 7'h41;
  localparam logic [6:0] ASCII_LOWER_A = 7'h61;

  typedef enum logic [1:0] {
    KEY_NONE = 2'd0,
    KEY_CHAR = 2'd1,
    KEY_BKSP = 2'd2
  } key_kind_e;

  typedef struct packed {
    key_kind_e  kind;
    logic [6:0] ch;
  } key_evt_t;

  function automatic logic [6:0] letter_ascii(input logic [4:0] idx, input logic upper);
    return (upper ? ASCII_UPPER_A : ASCII_LOWER_A) + {2'b00, idx};
  endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// rtl/scancode_to_ascii.sv - combinational set-2 scan code to ASCII decoder
module scancode_to_ascii
  import kbd_pkg::*;
(
  input  logic [8:0] code,
  input  logic       upper,
  input  logic       digits_en,
  output logic [6:0] ascii,
  output logic       is_char
);

  logic [4:0] w_letter;
  logic       w_is_letter;
  logic [3:0] w_digit;
  logic       w_is_digit;

  always_comb begin
    w_is_letter = 1'b1;
    w_letter    = 5'd0;
    case (code)
      9'h01C: w_letter = 5'd0;
      9'h032: w_letter = 5'd1;
      9'h021: w_letter = 5'd2;
      9'h023: w_letter = 5'd3;
      9'h024: w_letter = 5'd4;
      9'h02B: w_letter = 5'd5;
      9'h034: w_letter = 5'd6;
      9'h033: w_letter = 5'd7;
      9'h043: w_letter = 5'd8;
      9'h03B: w_letter = 5'd9;
      9'h042: w_letter = 5'd10;
      9'h04B: w_letter = 5'd11;
      9'h03A: w_letter = 5'd12;
      9'h031: w_letter = 5'd13;
      9'h044: w_letter = 5'd14;
      9'h04D: w_letter = 5'd15;
      9'h015: w_letter = 5'd16;
      9'h02D: w_letter = 5'd17;
      9'h01B: w_letter = 5'd18;
      9'h02C: w_letter = 5'd19;
      9'h03C: w_letter = 5'd20;
      9'h02A: w_letter = 5'd21;
      9'h01D: w_letter = 5'd22;
      9'h022: w_letter = 5'd23;
      9'h035: w_letter = 5'd24;
      9'h01A: w_letter = 5'd25;
      default: w_is_letter = 1'b0;
    endcase
  end

  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'd0;
    case (code)
      9'h045: w_digit = 4'd0;
      9'h016: w_digit = 4'd1;
      9'h01E: w_digit = 4'd2;
      9'h026: w_digit = 4'd3;
      9'h025: w_digit = 4'd4;
      9'h02E: w_digit = 4'd5;
      9'h036: w_digit = 4'd6;
      9'h03D: w_digit = 4'd7;
      9'h03E: w_digit = 4'd8;
      9'h046: w_digit = 4'd9;
      default: w_is_digit = 1'b0;
    endcase
  end

  // Enter stays live even in letters-only mode
  always_comb begin
    ascii   = ASCII_NUL;
    is_char = 1'b0;
    if (w_is_letter) begin
      ascii   = letter_ascii(w_letter, upper);
      is_char = 1'b1;
    end else if (code == SC_ENTER) begin
      ascii   = ASCII_CR;
      is_char = 1'b1;
    end else if (digits_en) begin
      if (w_is_digit) begin
        ascii   = ASCII_ZERO + {3'b000, w_digit};
        is_char = 1'b1;
      end else if (code == SC_SPACE) begin
        ascii   = ASCII_SPACE;
        is_char = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keyboard_ascii_fifo.sv
// rtl/keyboard_ascii_fifo.sv - keyboard press decoder feeding an ASCII character FIFO
module keyboard_ascii_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit CAPS_HOLD = 1'b0,
  parameter bit DIGITS_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [511:0]             key_down,
  input  logic [8:0]               last_change,
  input  logic                     key_valid,
  input  logic                     rd_en,
  output logic [6:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     caps,
  output logic                     overflow
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic            w_press;
  logic            w_shift;
  logic [6:0]      w_ascii;
  logic            w_is_char;
  logic            r_caps;
  key_evt_t        r_evt;

  logic [6:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [AW:0]     r_count;
  logic            r_overflow;

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_wr;
  logic            w_bs;
  logic            w_drop;
  logic [AW:0]     w_count_nxt;

  assign w_press = key_valid && key_down[last_change];
  assign w_shift = key_down[SC_SHIFT_L] | key_down[SC_SHIFT_R];

  scancode_to_ascii u_decode (
    .code      (last_change),
    .upper     (r_caps ^ w_shift),
    .digits_en (DIGITS_EN),
    .ascii     (w_ascii),
    .is_char   (w_is_char)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_caps <= 1'b0;
    end else if (CAPS_HOLD) begin
      r_caps <= key_down[SC_CAPS];
    end else if (w_press && (last_change == SC_CAPS)) begin
      r_caps <= ~r_caps;
    end
  end

  // One-stage event register between decode and the FIFO update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_evt <= '{kind: KEY_NONE, ch: ASCII_NUL};
    end else begin
      r_evt.ch <= w_ascii;
      if (!w_press)
        r_evt.kind <= KEY_NONE;
      else if (last_change == SC_BKSP)
        r_evt.kind <= KEY_BKSP;
      else if (w_is_char)
        r_evt.kind <= KEY_CHAR;
      else
        r_evt.kind <= KEY_NONE;
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = rd_en && !w_empty;
  // A pop of the sole entry already removes the character backspace would target
  assign w_bs    = (r_evt.kind == KEY_BKSP) && !w_empty &&
                   !(w_pop && (r_count == (AW+1)'(1)));
  assign w_wr    = (r_evt.kind == KEY_CHAR) && (!w_full || w_pop);
  assign w_drop  = (r_evt.kind == KEY_CHAR) && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_pop)
      w_count_nxt = r_count + (AW+1)'(1);
    else if (!w_wr && w_pop && w_bs)
      w_count_nxt = r_count - (AW+1)'(2);
    else if (!w_wr && (w_pop ^ w_bs))
      w_count_nxt = r_count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_tail] <= r_evt.ch;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_pop)
        r_head <= r_head + AW'(1);
      if (w_wr)
        r_tail <= r_tail + AW'(1);
      else if (w_bs)
        r_tail <= r_tail - AW'(1);
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  assign rd_data  = w_empty ? ASCII_NUL : r_mem[r_head];
  assign rd_valid = !w_empty;
  assign count    = r_count;
  assign caps     = r_caps;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_keyboard_ascii_fifo.sv
// tb/tb_keyboard_ascii_fifo.sv - self-checking bench for keyboard_ascii_fifo
`timescale 1ns/1ps
module tb_keyboard_ascii_fifo;

  localparam int DEPTH = 8;
  localparam logic [8:0] K_SHIFT_L = 9'h012;
  localparam logic [8:0] K_SHIFT_R = 9'h059;
  localparam logic [8:0] K_CAPS    = 9'h058;
  localparam logic [8:0] K_BKSP    = 9'h066;
  localparam logic [8:0] K_ENTER   = 9'h05A;
  localparam logic [8:0] K_SPACE   = 9'h029;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] key_down = '0;
  logic [8:0]   last_change = '0;
  logic         key_valid = 1'b0;
  logic         rd_en = 1'b0;
  logic [6:0]   rd_data;
  logic         rd_valid;
  logic [3:0]   count;
  logic         caps;
  logic         overflow;

  int tests_run = 0;
  int tests_failed = 0;

  logic [6:0] q[$];
  bit         m_caps, m_ovf, m_pend_ch, m_pend_bs;
  logic [6:0] m_pend_val;

  keyboard_ascii_fifo #(.DEPTH(DEPTH), .CAPS_HOLD(1'b0), .DIGITS_EN(1'b1)) dut (
    .clk(clk), .rst(rst_n), .key_down(key_down), .last_change(last_change),
    .key_valid(key_valid), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .caps(caps), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic bit ref_ascii(input logic [8:0] code, input bit upper, output logic [6:0] ch);
    logic [8:0] lc [26] = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034, 9'h033, 9'h043,
                            9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044, 9'h04D, 9'h015, 9'h02D,
                            9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D, 9'h022, 9'h035, 9'h01A};
    logic [8:0] dc [10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
    ch = 7'h00;
    for (int i = 0; i < 26; i++)
      if (code == lc[i]) begin
        ch = 7'(i + (upper ? 65 : 97));
        return 1'b1;
      end
    for (int i = 0; i < 10; i++)
      if (code == dc[i]) begin
        ch = 7'(48 + i);
        return 1'b1;
      end
    if (code == K_SPACE) begin ch = 7'h20; return 1'b1; end
    if (code == K_ENTER) begin ch = 7'h0D; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_caps = 0; m_ovf = 0; m_pend_ch = 0; m_pend_bs = 0; m_pend_val = '0;
  endtask

  // One clock of the reference: last cycle's press acts on the queue, then this cycle's press is decoded
  task automatic model_step(input bit kv, input logic [8:0] code, input bit rd);
    bit pop;
    bit upper;
    logic [6:0] ch;
    pop = rd && (q.size() > 0);
    if (m_pend_bs) begin
      if (q.size() == 0) begin
      end else if (pop && q.size() == 1) begin
        void'(q.pop_front());
      end else begin
        if (pop) void'(q.pop_front());
        void'(q.pop_back());
      end
    end else if (m_pend_ch) begin
      if (pop) begin
        void'(q.pop_front());
        q.push_back(m_pend_val);
      end else if (q.size() < DEPTH) q.push_back(m_pend_val);
      else m_ovf = 1;
    end else if (pop) begin
      void'(q.pop_front());
    end
    m_pend_ch = 0;
    m_pend_bs = 0;
    if (kv && key_down[code]) begin
      upper = m_caps ^ (key_down[K_SHIFT_L] | key_down[K_SHIFT_R]);
      if (code == K_BKSP) m_pend_bs = 1;
      else if (ref_ascii(code, upper, ch)) begin m_pend_ch = 1; m_pend_val = ch; end
      if (code == K_CAPS) m_caps = !m_caps;
    end
  endtask

  task automatic drive(input bit kv, input logic [8:0] code, input bit down, input bit rd);
    if (kv) key_down[code] = down;
    key_valid = kv;
    last_change = code;
    rd_en = rd;
    model_step(kv, code, rd);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic press(input logic [8:0] code, input bit rd);
    drive(1'b1, code, 1'b1, rd);
  endtask

  task automatic release_key(input logic [8:0] code, input bit rd);
    drive(1'b1, code, 1'b0, rd);
  endtask

  task automatic idle(input bit rd);
    drive(1'b0, 9'h000, 1'b0, rd);
  endtask

  task automatic type_key(input logic [8:0] code);
    press(code, 1'b0);
    release_key(code, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    key_down = '0;
    key_valid = 1'b0;
    rd_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (rd_valid !== 1'b0 || count !== 4'd0 || rd_data !== 7'h00 || caps !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state got v=%b cnt=%0d d=%h caps=%b ovf=%b exp all zero", rd_valid, count, rd_data, caps, overflow);
    end
  endtask

  task automatic test_single_press();
    do_reset();
    press(9'h01C, 1'b0);
    tests_run++;
    if (rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_n1 rd_valid got=%b exp=0", rd_valid);
    end
    release_key(9'h01C, 1'b0);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 7'h61 || count !== 4'd1) begin
      tests_failed++;
      $display("FAIL single_a got v=%b d=%h cnt=%0d exp v=1 d=61 cnt=1", rd_valid, rd_data, count);
    end
    idle(1'b1);
    tests_run++;
    if (rd_valid !== 1'b0 || count !== 4'(q.size())) begin
      tests_failed++;
      $display("FAIL single_pop got v=%b cnt=%0d exp v=0 cnt=%0d", rd_valid, count, q.size());
    end
  endtask

  task automatic test_caps_shift();
    do_reset();
    type_key(K_CAPS);
    tests_run++;
    if (caps !== 1'b1) begin
      tests_failed++;
      $display("FAIL caps_toggle got=%b exp=1", caps);
    end
    press(K_SHIFT_L, 1'b0);
    type_key(9'h01C);
    release_key(K_SHIFT_L, 1'b0);
    type_key(9'h01C);
    tests_run++;
    if (count !== 4'd2 || rd_data !== 7'h61) begin
      tests_failed++;
      $display("FAIL caps_shift_head got cnt=%0d d=%h exp cnt=2 d=61", count, rd_data);
    end
    idle(1'b1);
    tests_run++;
    if (rd_data !== 7'h41 || rd_data !== q[0]) begin
      tests_failed++;
      $display("FAIL caps_only_upper got=%h exp=41", rd_data);
    end
    idle(1'b1);
  endtask

  task automatic test_digits();
    logic [8:0] codes [4] = '{9'h045, 9'h046, K_SPACE, K_ENTER};
    logic [6:0] exp [4] = '{7'h30, 7'h39, 7'h20, 7'h0D};
    do_reset();
    type_key(K_CAPS);
    press(K_SHIFT_R, 1'b0);
    for (int i = 0; i < 4; i++) type_key(codes[i]);
    type_key(K_SHIFT_L);
    release_key(K_SHIFT_R, 1'b0);
    type_key(9'h076);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_data !== exp[i] || count !== 4'(4 - i)) begin
        tests_failed++;
        $display("FAIL digits_%0d got d=%h cnt=%0d exp d=%h cnt=%0d", i, rd_data, count, exp[i], 4 - i);
      end
      idle(1'b1);
    end
  endtask

  task automatic test_overflow();
    logic [8:0] codes [9] = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034, 9'h033, 9'h043};
    do_reset();
    for (int i = 0; i < 9; i++) type_key(codes[i]);
    tests_run++;
    if (count !== 4'd8 || overflow !== 1'b1 || rd_data !== 7'h61) begin
      tests_failed++;
      $display("FAIL overflow got cnt=%0d ovf=%b d=%h exp cnt=8 ovf=1 d=61", count, overflow, rd_data);
    end
    idle(1'b1);
    tests_run++;
    if (overflow !== 1'b1 || count !== 4'd7) begin
      tests_failed++;
      $display("FAIL overflow_sticky got ovf=%b cnt=%0d exp ovf=1 cnt=7", overflow, count);
    end
  endtask

  task automatic test_write_pop_full();
    logic [8:0] codes [8] = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034, 9'h033};
    logic [6:0] last;
    do_reset();
    for (int i = 0; i < 8; i++) type_key(codes[i]);
    press(9'h01A, 1'b0);
    release_key(9'h01A, 1'b1);
    tests_run++;
    if (count !== 4'd8 || overflow !== 1'b0 || rd_data !== 7'h62) begin
      tests_failed++;
      $display("FAIL full_wr_pop got cnt=%0d ovf=%b d=%h exp cnt=8 ovf=0 d=62", count, overflow, rd_data);
    end
    last = 7'h00;
    for (int i = 0; i < 8; i++) begin
      last = rd_data;
      idle(1'b1);
    end
    tests_run++;
    if (last !== 7'h7A || count !== 4'd0) begin
      tests_failed++;
      $display("FAIL full_tail got last=%h cnt=%0d exp last=7a cnt=0", last, count);
    end
  endtask

  task automatic test_backspace();
    do_reset();
    type_key(9'h01C);
    type_key(9'h032);
    type_key(K_BKSP);
    tests_run++;
    if (count !== 4'd1 || rd_data !== 7'h61) begin
      tests_failed++;
      $display("FAIL bksp got cnt=%0d d=%h exp cnt=1 d=61", count, rd_data);
    end
    idle(1'b1);
    type_key(K_BKSP);
    tests_run++;
    if (count !== 4'd0 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bksp_empty got cnt=%0d v=%b exp cnt=0 v=0", count, rd_valid);
    end
  endtask

  task automatic test_bksp_pop();
    do_reset();
    type_key(9'h01C);
    press(K_BKSP, 1'b0);
    release_key(K_BKSP, 1'b1);
    tests_run++;
    if (count !== 4'd0 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bksp_pop_one got cnt=%0d v=%b exp cnt=0 v=0", count, rd_valid);
    end
    type_key(9'h01C);
    type_key(9'h032);
    type_key(9'h021);
    press(K_BKSP, 1'b0);
    release_key(K_BKSP, 1'b1);
    tests_run++;
    if (count !== 4'd1 || rd_data !== 7'h62) begin
      tests_failed++;
      $display("FAIL bksp_pop_many got cnt=%0d d=%h exp cnt=1 d=62", count, rd_data);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    type_key(K_CAPS);
    key_down[9'h01C] = 1'b1;
    key_valid = 1'b1;
    last_change = 9'h01C;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_down = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle(1'b0);
    tests_run++;
    if (rd_valid !== 1'b0 || count !== 4'd0 || caps !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midflight got v=%b cnt=%0d caps=%b exp 0 0 0", rd_valid, count, caps);
    end
  endtask

  task automatic test_random();
    logic [8:0] pool [14] = '{9'h01C, 9'h01A, 9'h03A, 9'h015, 9'h045, 9'h03E, K_SPACE, K_ENTER,
                              K_BKSP, K_SHIFT_L, K_SHIFT_R, K_CAPS, 9'h076, 9'h00D};
    logic [8:0] code;
    logic [6:0] exp_d;
    int rd_pct;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      rd_pct = ((cyc / 100) % 2 == 0) ? 10 : 60;
      if ($urandom_range(0, 9) < 6) begin
        code = pool[$urandom_range(0, 13)];
        drive(1'b1, code, !key_down[code], $urandom_range(0, 99) < rd_pct);
      end else begin
        idle($urandom_range(0, 99) < rd_pct);
      end
      exp_d = (q.size() > 0) ? q[0] : 7'h00;
      tests_run++;
      if (rd_data !== exp_d || rd_valid !== (q.size() > 0) || count !== 4'(q.size()) ||
          caps !== m_caps || overflow !== m_ovf) begin
        tests_failed++;
        $display("FAIL random cyc=%0d got d=%h v=%b cnt=%0d caps=%b ovf=%b exp d=%h v=%b cnt=%0d caps=%b ovf=%b",
                 cyc, rd_data, rd_valid, count, caps, overflow, exp_d, q.size() > 0, q.size(), m_caps, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_caps_shift();
    test_digits();
    test_overflow();
    test_write_pop_full();
    test_backspace();
    test_bksp_pop();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
